// File: rtl/cpu_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl_if
// Brief    : Control and clock-enable bundle between the board/core side
//            and the CPU run/step/halt clock controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_clk_ctrl_if #(
    parameter int DIV_W = 24
);
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             cpu_ce;
    logic             mem_ce;
    logic             running;
    logic             halted;
    logic [31:0]      cycle_count;

    // Board switches and core requests drive the controller
    modport master (
        output run_sw, step_btn, halt_req, div_load, div_value,
        input  cpu_ce, mem_ce, running, halted, cycle_count
    );

    // The controller itself
    modport slave (
        input  run_sw, step_btn, halt_req, div_load, div_value,
        output cpu_ce, mem_ce, running, halted, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl
// Brief    : Run/step/halt controller producing one-cycle CPU and memory
//            clock enables in the clkin domain. mem_ce fires mid-period,
//            cpu_ce at the end of each period of div_reg cycles.
//            Optional macro CPU_CLK_CTRL_CYCLE_CNT_EN enables the 32-bit
//            cpu_ce pulse counter on cycle_count (tied to 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_clk_ctrl #(
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 10000,
    parameter int DB_CYCLES   = 1000000
) (
    input  wire logic     clkin,
    input  wire logic     reset,
    cpu_clk_ctrl_if.slave bus
);

    localparam int               c_DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0]  c_DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0]  c_DIV_RST = DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_run_s1, r_run_s2;
    logic               r_step_s1, r_step_s2;
    logic               r_db_level;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic               r_step_evt;

    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic               r_pend_valid;
    logic [DIV_W-1:0]   r_pend_val;
    logic               r_halt_latch;
    logic               r_cpu_ce;
    logic               r_mem_ce;

    logic [DIV_W-1:0]   w_div_clamped;
    logic               w_wrap;
    logic [DIV_W-1:0]   w_div_next;
    logic               w_pend_next;
    logic [DIV_W-1:0]   w_pend_val_next;
    logic [DIV_W-1:0]   w_cnt_next;
    logic               w_cpu_next;
    logic               w_mem_next;

    // Two-flop synchronisers for the asynchronous switch and button
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
        end else begin
            r_run_s1  <= bus.run_sw;
            r_run_s2  <= r_run_s1;
            r_step_s1 <= bus.step_btn;
            r_step_s2 <= r_step_s1;
        end
    end

    // Debounce: the level flips after DB_CYCLES consecutive differing samples;
    // a flip to 1 produces a one-cycle step event on the following cycle
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
            r_step_evt <= 1'b0;
        end else begin
            r_step_evt <= 1'b0;
            if (r_step_s2 != r_db_level) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_db_level <= r_step_s2;
                    r_db_cnt   <= '0;
                    r_step_evt <= r_step_s2;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_div_clamped = (bus.div_value < c_DIV_MIN) ? c_DIV_MIN : bus.div_value;
    assign w_wrap        = (r_state != ST_HALT) && (r_cnt == r_div - DIV_W'(1));

    // Next-state decode; a started period always runs to its cpu_ce
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (r_run_s2 && !r_halt_latch) begin
                    w_state_next = ST_RUN;
                end else if (r_step_evt && !r_run_s2) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (r_cpu_ce && (!r_run_s2 || r_halt_latch || bus.halt_req)) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                if (r_cpu_ce) begin
                    w_state_next = ST_HALT;
                end
            end
            default: w_state_next = ST_HALT;
        endcase
    end

    // Divisor update: immediate in HALT, otherwise deferred to the period wrap
    always_comb begin
        w_div_next      = r_div;
        w_pend_next     = r_pend_valid;
        w_pend_val_next = r_pend_val;
        if (r_state == ST_HALT) begin
            if (bus.div_load) begin
                w_div_next = w_div_clamped;
            end
        end else begin
            if (bus.div_load) begin
                w_pend_next     = 1'b1;
                w_pend_val_next = w_div_clamped;
            end
            if (w_wrap) begin
                if (w_pend_next) begin
                    w_div_next = w_pend_val_next;
                end
                w_pend_next = 1'b0;
            end
        end
    end

    // Counter and enable look-ahead so cpu_ce/mem_ce can be registered
    always_comb begin
        w_cnt_next = r_cnt + DIV_W'(1);
        if ((r_state == ST_HALT) || (w_state_next == ST_HALT) || w_wrap) begin
            w_cnt_next = '0;
        end
        w_mem_next = (w_state_next != ST_HALT) &&
                     (w_cnt_next == (w_div_next >> 1) - DIV_W'(1));
        w_cpu_next = (w_state_next != ST_HALT) &&
                     (w_cnt_next == w_div_next - DIV_W'(1));
    end

    // State, period counter, divisor and registered enables
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HALT;
            r_cnt        <= '0;
            r_div        <= c_DIV_RST;
            r_pend_valid <= 1'b0;
            r_pend_val   <= '0;
            r_cpu_ce     <= 1'b0;
            r_mem_ce     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_div        <= w_div_next;
            r_pend_valid <= w_pend_next;
            r_pend_val   <= w_pend_val_next;
            r_cpu_ce     <= w_cpu_next;
            r_mem_ce     <= w_mem_next;
        end
    end

    // Halt latch: captures a core halt on a cpu_ce, released by run switch off
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_halt_latch <= 1'b0;
        end else if (!r_run_s2) begin
            r_halt_latch <= 1'b0;
        end else if (bus.halt_req && r_cpu_ce) begin
            r_halt_latch <= 1'b1;
        end
    end

    assign bus.cpu_ce  = r_cpu_ce;
    assign bus.mem_ce  = r_mem_ce;
    assign bus.running = (r_state == ST_RUN);
    assign bus.halted  = (r_state == ST_HALT);

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    logic [31:0] r_cycle_count;

    // Free-running count of cpu_ce pulses, cleared only by reset
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_cycle_count <= 32'd0;
        end else if (r_cpu_ce) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign bus.cycle_count = r_cycle_count;
`else
    assign bus.cycle_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clk_ctrl
// Brief    : Directed self-checking bench for cpu_clk_ctrl with
//            DEFAULT_DIV=4 and DB_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clk_ctrl;

    localparam int DIV_W = 24;

    logic clkin = 1'b0;
    logic reset = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clkin = ~clkin;

    cpu_clk_ctrl_if #(.DIV_W(DIV_W)) bus ();

    cpu_clk_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (4),
        .DB_CYCLES   (4)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    // Single comparison point: counts every vector, reports miscompares
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.cpu_ce;
            1:       return bus.mem_ce;
            2:       return bus.halted;
            default: return !bus.halted;
        endcase
    endfunction

    // Wait (bounded) until the selected condition holds; timeout is a miscompare
    task automatic wait_until(input string tag, input int sel, input int bound);
        int hit;
        hit = 0;
        for (int i = 0; i < bound; i++) begin
            if (sig(sel)) begin
                hit = 1;
                break;
            end
            tick();
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    // Count clock edges until the selected condition holds (bounded)
    task automatic count_until(input int sel, input int bound, output int n);
        n = 0;
        while (n < bound && !sig(sel)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int mem_cnt, cpu_cnt, mem_off, cpu_off, halted_at;
        logic [31:0] exp_cc;

        bus.run_sw    = 1'b0;
        bus.step_btn  = 1'b0;
        bus.halt_req  = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        reset = 1'b1;
        repeat (2) tick();

        // Reset values
        check("rst_cpu_ce",  32'(bus.cpu_ce),  32'd0);
        check("rst_mem_ce",  32'(bus.mem_ce),  32'd0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_halted",  32'(bus.halted),  32'd1);
        check("rst_cycle_count", bus.cycle_count, 32'd0);

        // 1: continuous run, period 4, mem at offset 1, cpu at offset 3
        bus.run_sw = 1'b1;
        reset = 1'b0;
        count_until(3, 10, n);
        check("run_latency", 32'(n), 32'd3);
        for (int off = 0; off < 40; off++) begin
            check("run_mem_ce", 32'(bus.mem_ce), 32'((off % 4) == 1));
            check("run_cpu_ce", 32'(bus.cpu_ce), 32'((off % 4) == 3));
            tick();
        end
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        exp_cc = 32'd10;
`else
        exp_cc = 32'd0;
`endif
        check("cycle_count_10", bus.cycle_count, exp_cc);
        bus.run_sw = 1'b0;
        repeat (3) tick();
        check("stop_finishes_period", 32'(bus.cpu_ce), 32'd1);
        tick();
        check("stop_halted",  32'(bus.halted),  32'd1);
        check("stop_running", 32'(bus.running), 32'd0);

        // 2: single step with bounce; divisor 20 so a second press lands in STEP
        bus.div_load  = 1'b1;
        bus.div_value = 24'd20;
        tick();
        bus.div_load  = 1'b0;
        bus.step_btn  = 1'b1;
        tick();
        bus.step_btn  = 1'b0;
        tick();
        bus.step_btn  = 1'b1;
        wait_until("step_entry", 3, 30);
        check("step_not_running", 32'(bus.running), 32'd0);
        bus.step_btn = 1'b0;
        mem_cnt = 0; cpu_cnt = 0; mem_off = -1; cpu_off = -1; halted_at = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 8)  bus.step_btn = 1'b1;
            if (k == 20) bus.step_btn = 1'b0;
            if (bus.mem_ce) begin mem_cnt++; mem_off = k; end
            if (bus.cpu_ce) begin cpu_cnt++; cpu_off = k; end
            if (k == 20) halted_at = int'(bus.halted);
            tick();
        end
        check("step_mem_count",  32'(mem_cnt), 32'd1);
        check("step_cpu_count",  32'(cpu_cnt), 32'd1);
        check("step_mem_offset", 32'(mem_off), 32'd9);
        check("step_cpu_offset", 32'(cpu_off), 32'd19);
        check("step_halt_after", 32'(halted_at), 32'd1);
        check("step_end_halted", 32'(bus.halted), 32'd1);
        bus.div_load  = 1'b1;
        bus.div_value = 24'd4;
        tick();
        bus.div_load  = 1'b0;

        // 3: halt request handling
        bus.run_sw = 1'b1;
        wait_until("hr_run_entry", 3, 10);
        wait_until("hr_wait_mem", 1, 10);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        wait_until("hr_wait_cpu1", 0, 10);
        tick();
        check("hr_ignored_off_ce", 32'(bus.running), 32'd1);
        wait_until("hr_wait_cpu2", 0, 10);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check("hr_halt_next", 32'(bus.halted), 32'd1);
        repeat (10) tick();
        check("hr_stays_halted", 32'(bus.halted), 32'd1);
        bus.run_sw = 1'b0;
        repeat (4) tick();
        bus.run_sw = 1'b1;
        count_until(3, 10, n);
        check("hr_resume_latency", 32'(n), 32'd3);
        check("hr_resumed", 32'(bus.running), 32'd1);

        // 4: divisor load in RUN deferred to the period wrap
        wait_until("dl_wait_mem", 1, 10);
        bus.div_load  = 1'b1;
        bus.div_value = 24'd6;
        tick();
        bus.div_load  = 1'b0;
        check("dl_cnt2_cpu", 32'(bus.cpu_ce), 32'd0);
        tick();
        check("dl_old_period_end", 32'(bus.cpu_ce), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("dl6_mem_ce", 32'(bus.mem_ce), 32'(((k - 1) % 6) == 2));
            check("dl6_cpu_ce", 32'(bus.cpu_ce), 32'(((k - 1) % 6) == 5));
        end

        // 5: divisor 0 clamps to 2, enables alternate
        bus.run_sw = 1'b0;
        wait_until("cl_halt", 2, 20);
        bus.div_load  = 1'b1;
        bus.div_value = 24'd0;
        tick();
        bus.div_load  = 1'b0;
        bus.run_sw    = 1'b1;
        wait_until("cl_run", 3, 10);
        for (int off = 0; off < 8; off++) begin
            check("cl_mem_ce", 32'(bus.mem_ce), 32'((off % 2) == 0));
            check("cl_cpu_ce", 32'(bus.cpu_ce), 32'((off % 2) == 1));
            tick();
        end

        // 6: reset at cnt=2 in RUN, then full run latency again
        bus.div_load  = 1'b1;
        bus.div_value = 24'd4;
        tick();
        bus.div_load  = 1'b0;
        wait_until("rr_wait_cpu", 0, 10);
        tick();
        wait_until("rr_wait_mem", 1, 10);
        tick();
        reset = 1'b1;
        #1;
        check("rr_cpu_ce",  32'(bus.cpu_ce),  32'd0);
        check("rr_mem_ce",  32'(bus.mem_ce),  32'd0);
        check("rr_halted",  32'(bus.halted),  32'd1);
        check("rr_running", 32'(bus.running), 32'd0);
        check("rr_cycle_count", bus.cycle_count, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        count_until(3, 10, n);
        check("rr_run_latency", 32'(n), 32'd3);
        count_until(0, 10, n);
        check("rr_first_cpu", 32'(n), 32'd3);
        check("rr_count_before", bus.cycle_count, 32'd0);
        tick();
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        exp_cc = 32'd1;
`else
        exp_cc = 32'd0;
`endif
        check("rr_count_after", bus.cycle_count, exp_cc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run/step/halt controller for the CPU clock path. Replaces a free-running divided clock with single-cycle enable pulses (`cpu_ce`, `mem_ce`) in the `clkin` domain. Sequences the MIPS core through continuous run, single-step from a board button, and halt on a core request. Sits between the board clock/switches and the CPU/memory clock-enable inputs.

## Interface
- `DIV_W`, 24, width of the divisor and period counter
- `DEFAULT_DIV`, 10000, divisor loaded at reset (`clkin` cycles per CPU cycle)
- `DB_CYCLES`, 1000000, number of stable `clkin` cycles for a step-button debounce
- `clkin` input 1, system clock; the only clock
- `reset` input 1, asynchronous, active-high; clears all state
- `run_sw` input 1, raw run switch (asynchronous level)
- `step_btn` input 1, raw step button (asynchronous, bouncing)
- `halt_req` input 1, synchronous halt request from the core (for example, `break`)
- `div_load` input 1, one-cycle strobe that loads `div_value`
- `div_value` input DIV_W, new divisor
- `cpu_ce` output 1, one-`clkin`-cycle CPU clock enable
- `mem_ce` output 1, one-`clkin`-cycle memory clock enable at mid-period
- `running` output 1, high in state RUN
- `halted` output 1, high in state HALT
- `cycle_count` output 32, count of `cpu_ce` pulses (see Configuration)

## Operation
- Synchronisation:
  - `run_sw` and `step_btn` each pass through a 2-flop synchroniser.
  - The synchronised `step_btn` is debounced. The debounced level changes only after `DB_CYCLES` consecutive equal samples.
  - A step event is the rising edge of the debounced level.
- Divisor:
  - `div_reg` resets to `DEFAULT_DIV`.
  - Values below 2 are clamped to 2.
  - `div_load` in HALT takes effect immediately.
  - `div_load` in RUN or STEP is held pending and applied when `cnt` wraps.
  - If a second load arrives while one is pending, the last value wins.
- Period counter `cnt` (DIV_W bits):
  - Counts 0..`div_reg`-1 and wraps to 0, only in RUN and STEP.
  - Forced to 0 in HALT.
  - `mem_ce` = 1 when `cnt == (div_reg>>1)-1`.
  - `cpu_ce` = 1 when `cnt == div_reg-1`.
  - Neither pulse is ever asserted in HALT.
- Halt latch:
  - `halt_latch` is set when `halt_req` is high in the same cycle as `cpu_ce`.
  - It is cleared when synchronised `run_sw` is 0.
- FSM states: HALT (reset state), RUN, STEP.
  - HALT → RUN when `run_sw_s && !halt_latch`. `cnt` starts at 0.
  - HALT → STEP on a step event while `!run_sw_s`. `cnt` starts at 0.
  - RUN → HALT on the cycle after a `cpu_ce` pulse if `!run_sw_s` or `halt_latch` (including a latch set that same cycle).
  - A period already in progress is always finished, so `mem_ce` never occurs without its following `cpu_ce`.
  - STEP → HALT on the cycle after its single `cpu_ce`.
  - Step events in RUN or STEP are ignored and are not queued.
- Simultaneous events:
  - `run_sw_s` rising in the same cycle as a step event in HALT: RUN wins.
  - `halt_req` outside a `cpu_ce` cycle is ignored.
- Reset mid-period:
  - All outputs drop immediately.
  - The state returns to HALT, `div_reg` to `DEFAULT_DIV`, and the pending load, latch and debounce state are cleared.

## Timing
- Reset values:
  - `cpu_ce` = 0, `mem_ce` = 0, `running` = 0, `halted` = 1, `cycle_count` = 0.
- `cpu_ce` and `mem_ce` are registered outputs.
- With `div_reg = D`, the period is exactly D `clkin` cycles.
  - `mem_ce` fires at offset `(D>>1)-1`.
  - `cpu_ce` fires at offset `D-1` from the first RUN/STEP cycle.
- `run_sw` to first `cpu_ce`: 2 synchroniser cycles + 1 FSM cycle + D cycles.
- Step press to `cpu_ce`: 2 + `DB_CYCLES` + 1 (edge) + 1 (FSM) + D cycles.
- `running`/`halted` update in the same cycle as the state register.

## Configuration
- Macro: `CPU_CLK_CTRL_CYCLE_CNT_EN`.
- Defined:
  - `cycle_count` increments by 1 (modulo 2^32) on every `cpu_ce`.
  - It is cleared only by `reset`.
- Undefined:
  - The counter logic is absent and `cycle_count` is tied to 32'd0.

## Test plan
Bench parameters: `DEFAULT_DIV`=4, `DB_CYCLES`=4.
1. Reset, `run_sw`=1 held → `halted` falls.
   - `mem_ce` and `cpu_ce` occur at FSM-cycle offsets 1 and 3, then repeat every 4 cycles.
   - `cycle_count` = 10 after 10 pulses.
2. In HALT, press `step_btn` with 3 bounce toggles, then hold 10 cycles → exactly one `mem_ce` and one `cpu_ce`, then `halted`=1. A second press during STEP is ignored.
3. RUN, assert `halt_req` on a `cpu_ce` cycle → HALT on the next cycle. With `run_sw` still 1 it stays halted. Toggling `run_sw` 0→1 resumes.
4. RUN, `div_load` with `div_value`=6 at `cnt`=1 → the current period still ends at offset 3. The next period is 6 cycles with `mem_ce` at offset 2.
5. `div_load` with `div_value`=0 in HALT → `div_reg`=2. In RUN, `mem_ce` and `cpu_ce` alternate every cycle.
6. Assert `reset` at `cnt`=2 in RUN → the outputs are 0 immediately and `halted`=1. After release, the first `cpu_ce` follows the full run latency. With the macro undefined, `cycle_count` stays 0 throughout.
